// File: rtl/t07_circle_sequencer_if.sv
// ----------------------------------------------------------------------------
// t07_circle_sequencer_if
// Bundles the game-side signals of the circle sequencer.
//   master : player/game logic. Drives start, move_valid, player_x, player_y.
//            Observes the sequencer outputs.
//   slave  : the sequencer itself. The directions are the reverse of master.
// Signals:
//   start         1  one-cycle pulse that begins a game
//   move_valid    1  one-cycle pulse when the player enters a block
//   player_x/y    3  player block column/row, 0..5
//   map_select    3  current map index to the circle generator
//   circle_active 2  bit i set while circle i is uncollected
//   collect_pulse 1  one-cycle pulse per collected circle
//   collect_count 4  circles collected this game (saturating)
//   level_done    1  one-cycle pulse when a map completes
//   game_done     1  high while the game is finished
// ----------------------------------------------------------------------------
interface t07_circle_sequencer_if;
  logic       start;
  logic       move_valid;
  logic [2:0] player_x;
  logic [2:0] player_y;
  logic [2:0] map_select;
  logic [1:0] circle_active;
  logic       collect_pulse;
  logic [3:0] collect_count;
  logic       level_done;
  logic       game_done;

  modport master (
    output start, move_valid, player_x, player_y,
    input  map_select, circle_active, collect_pulse, collect_count,
           level_done, game_done
  );

  modport slave (
    input  start, move_valid, player_x, player_y,
    output map_select, circle_active, collect_pulse, collect_count,
           level_done, game_done
  );
endinterface

// File: rtl/t07_circle_sequencer.sv
// ----------------------------------------------------------------------------
// t07_circle_sequencer
// This is the level controller for the circle overlay. It steps through the maps and
// tracks which of the two circles on each map are still uncollected. It reports
// level and game completion to the top-level game FSM.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : t07_circle_sequencer_if.slave (game handshake and outputs)
// Parameters:
//   NUM_MAPS    : maps sequenced, 0..NUM_MAPS-1 (at most 5)
//   HOLD_CYCLES : cycles spent in LEVEL_DONE before advancing (at least 1)
// ----------------------------------------------------------------------------
module t07_circle_sequencer #(
  parameter int NUM_MAPS    = 5,
  parameter int HOLD_CYCLES = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  t07_circle_sequencer_if.slave        bus
);

  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [2:0]    MAP_LAST  = 3'(NUM_MAPS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_PLAY, S_LEVEL_DONE, S_GAME_DONE
  } state_t;

  typedef struct packed {
    logic [2:0] x;
    logic [2:0] y;
  } pos_t;

  state_t       r_state;
  logic [CW-1:0] r_hold_cnt;
  logic [2:0]   r_map_select;
  logic [1:0]   r_circle_active;
  logic         r_collect_pulse;
  logic [3:0]   r_collect_count;
  logic         r_level_done;
  logic         r_game_done;

  pos_t         w_c0;
  pos_t         w_c1;
  logic [1:0]   w_hit;
  logic [1:0]   w_remaining;

  // Circle positions for the current map. The indices past the last map are
  // unreachable and default to the origin.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_c0 = '{x: 3'd0, y: 3'd0};
    w_c1 = '{x: 3'd0, y: 3'd0};
    case (r_map_select)
      3'd0: begin w_c0 = '{3'd0, 3'd3}; w_c1 = '{3'd5, 3'd4}; end
      3'd1: begin w_c0 = '{3'd1, 3'd4}; w_c1 = '{3'd4, 3'd2}; end
      3'd2: begin w_c0 = '{3'd0, 3'd2}; w_c1 = '{3'd2, 3'd2}; end
      3'd3: begin w_c0 = '{3'd5, 3'd5}; w_c1 = '{3'd5, 3'd2}; end
      3'd4: begin w_c0 = '{3'd1, 3'd3}; w_c1 = '{3'd2, 3'd0}; end
      default: ;
    endcase
  end

  // The table only holds coordinates 0..5, so off-grid moves (6, 7) never hit.
  // A circle that is already collected cannot hit again.
  assign w_hit[0] = r_circle_active[0] &&
                    bus.player_x == w_c0.x && bus.player_y == w_c0.y;
  assign w_hit[1] = r_circle_active[1] &&
                    bus.player_x == w_c1.x && bus.player_y == w_c1.y;
  assign w_remaining = r_circle_active & ~w_hit;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples values from before the edge.
  // NOTE: all state, including the hold counter, is reset; there is no storage
  // array whose contents could be left uninitialised.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_hold_cnt      <= '0;
      r_map_select    <= 3'd0;
      r_circle_active <= 2'b00;
      r_collect_pulse <= 1'b0;
      r_collect_count <= 4'd0;
      r_level_done    <= 1'b0;
      r_game_done     <= 1'b0;
    end else begin
      r_collect_pulse <= 1'b0;
      r_level_done    <= 1'b0;

      case (r_state)
        S_IDLE, S_GAME_DONE: begin
          r_circle_active <= 2'b00;
          if (bus.start) begin
            r_map_select    <= 3'd0;
            r_collect_count <= 4'd0;
            r_game_done     <= 1'b0;
            r_state         <= S_LOAD;
          end
        end

        S_LOAD: begin
          r_circle_active <= 2'b11;
          r_hold_cnt      <= '0;
          r_state         <= S_PLAY;
        end

        S_PLAY: begin
          if (bus.move_valid && (w_hit != 2'b00)) begin
            r_circle_active <= w_remaining;
            r_collect_pulse <= 1'b1;
            if (r_collect_count != 4'hF)
              r_collect_count <= r_collect_count + 4'd1;
            if (w_remaining == 2'b00)
              r_state <= S_LEVEL_DONE;
          end
        end

        S_LEVEL_DONE: begin
          if (r_hold_cnt == HOLD_LAST) begin
            r_level_done <= 1'b1;
            if (r_map_select == MAP_LAST) begin
              r_game_done <= 1'b1;
              r_state     <= S_GAME_DONE;
            end else begin
              r_map_select <= r_map_select + 3'd1;
              r_state      <= S_LOAD;
            end
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.map_select    = r_map_select;
  assign bus.circle_active = r_circle_active;
  assign bus.collect_pulse = r_collect_pulse;
  assign bus.collect_count = r_collect_count;
  assign bus.level_done    = r_level_done;
  assign bus.game_done     = r_game_done;

endmodule

// File: tb/tb_t07_circle_sequencer.sv
// ----------------------------------------------------------------------------
// tb_t07_circle_sequencer
// Directed bench for t07_circle_sequencer, run with a short hold time.
// A table of single-cycle vectors covers reset, the first map, ignored inputs,
// and the level transition. Hand-written sequences then cover asynchronous
// reset in PLAY, a full five-map game, and restart from GAME_DONE.
// ----------------------------------------------------------------------------
module tb_t07_circle_sequencer;

  localparam int HOLD = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  t07_circle_sequencer_if bus ();

  t07_circle_sequencer #(.NUM_MAPS(5), .HOLD_CYCLES(HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string      name;
    logic       start;
    logic       mv;
    logic [2:0] x;
    logic [2:0] y;
    logic [2:0] e_map;
    logic [1:0] e_act;
    logic       e_pulse;
    logic [3:0] e_cnt;
    logic       e_ld;
    logic       e_gd;
  } vec_t;

  vec_t vq[$];

  logic [2:0] cx [5][2];
  logic [2:0] cy [5][2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add_vec(input string name, input logic s, input logic mv,
                         input logic [2:0] x, input logic [2:0] y,
                         input logic [2:0] em, input logic [1:0] ea,
                         input logic ep, input logic [3:0] ec,
                         input logic eld, input logic egd);
    vec_t v;
    v.name = name; v.start = s; v.mv = mv; v.x = x; v.y = y;
    v.e_map = em; v.e_act = ea; v.e_pulse = ep; v.e_cnt = ec;
    v.e_ld = eld; v.e_gd = egd;
    vq.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [2:0] em, input logic [1:0] ea,
                           input logic ep, input logic [3:0] ec,
                           input logic eld, input logic egd);
    check({tag, ".map"},   32'(bus.map_select),    32'(em));
    check({tag, ".act"},   32'(bus.circle_active), 32'(ea));
    check({tag, ".pulse"}, 32'(bus.collect_pulse), 32'(ep));
    check({tag, ".cnt"},   32'(bus.collect_count), 32'(ec));
    check({tag, ".ld"},    32'(bus.level_done),    32'(eld));
    check({tag, ".gd"},    32'(bus.game_done),     32'(egd));
  endtask

  // Collect both circles of map m. Then wait for the level_done pulse and
  // check the hold length and the map that follows.
  task automatic play_level(input int m);
    int  n;
    bit  found;
    for (int c = 0; c < 2; c++) begin
      bus.move_valid = 1'b1;
      bus.player_x   = cx[m][c];
      bus.player_y   = cy[m][c];
      tick();
      bus.move_valid = 1'b0;
      check($sformatf("m%0d_c%0d.pulse", m, c), 32'(bus.collect_pulse), 32'd1);
      check($sformatf("m%0d_c%0d.cnt", m, c), 32'(bus.collect_count), 32'(2*m + c + 1));
      check($sformatf("m%0d_c%0d.act", m, c), 32'(bus.circle_active),
            (c == 0) ? 32'd2 : 32'd0);
    end
    n = 0;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      tick();
      n++;
      if (bus.level_done) found = 1'b1;
    end
    check($sformatf("m%0d.ld_seen", m), 32'(found), 32'd1);
    check($sformatf("m%0d.hold_len", m), 32'(n), 32'(HOLD));
    check($sformatf("m%0d.next_map", m), 32'(bus.map_select), (m == 4) ? 32'd4 : 32'(m + 1));
    if (m < 4) begin
      tick();
      check($sformatf("m%0d.reload", m), 32'(bus.circle_active), 32'd3);
      check($sformatf("m%0d.ld_pulse_end", m), 32'(bus.level_done), 32'd0);
    end else begin
      check("final.gd", 32'(bus.game_done), 32'd1);
      check("final.act", 32'(bus.circle_active), 32'd0);
      check("final.cnt", 32'(bus.collect_count), 32'd10);
    end
  endtask

  initial begin
    cx[0][0] = 3'd0; cy[0][0] = 3'd3; cx[0][1] = 3'd5; cy[0][1] = 3'd4;
    cx[1][0] = 3'd1; cy[1][0] = 3'd4; cx[1][1] = 3'd4; cy[1][1] = 3'd2;
    cx[2][0] = 3'd0; cy[2][0] = 3'd2; cx[2][1] = 3'd2; cy[2][1] = 3'd2;
    cx[3][0] = 3'd5; cy[3][0] = 3'd5; cx[3][1] = 3'd5; cy[3][1] = 3'd2;
    cx[4][0] = 3'd1; cy[4][0] = 3'd3; cx[4][1] = 3'd2; cy[4][1] = 3'd0;

    //        name           st mv  x     y     map   act    p  cnt   ld gd
    add_vec("idle_mv",       0, 1, 3'd0, 3'd3, 3'd0, 2'b00, 0, 4'd0, 0, 0);
    add_vec("start",         1, 0, 3'd0, 3'd0, 3'd0, 2'b00, 0, 4'd0, 0, 0);
    add_vec("load",          0, 0, 3'd0, 3'd0, 3'd0, 2'b11, 0, 4'd0, 0, 0);
    add_vec("hit_c0",        0, 1, 3'd0, 3'd3, 3'd0, 2'b10, 1, 4'd1, 0, 0);
    add_vec("pulse_end",     0, 0, 3'd0, 3'd0, 3'd0, 2'b10, 0, 4'd1, 0, 0);
    add_vec("repeat_c0",     0, 1, 3'd0, 3'd3, 3'd0, 2'b10, 0, 4'd1, 0, 0);
    add_vec("coord7",        0, 1, 3'd7, 3'd4, 3'd0, 2'b10, 0, 4'd1, 0, 0);
    add_vec("start_in_play", 1, 0, 3'd0, 3'd0, 3'd0, 2'b10, 0, 4'd1, 0, 0);
    add_vec("hit_c1",        0, 1, 3'd5, 3'd4, 3'd0, 2'b00, 1, 4'd2, 0, 0);
    add_vec("hold1_mv",      0, 1, 3'd0, 3'd3, 3'd0, 2'b00, 0, 4'd2, 0, 0);
    add_vec("hold2_start",   1, 0, 3'd0, 3'd0, 3'd0, 2'b00, 0, 4'd2, 0, 0);
    add_vec("level_done",    0, 0, 3'd0, 3'd0, 3'd1, 2'b00, 0, 4'd2, 1, 0);
    add_vec("load_map1",     0, 0, 3'd0, 3'd0, 3'd1, 2'b11, 0, 4'd2, 0, 0);
    add_vec("x6",            0, 1, 3'd6, 3'd3, 3'd1, 2'b11, 0, 4'd2, 0, 0);
    add_vec("wrong_map_pos", 0, 1, 3'd5, 3'd4, 3'd1, 2'b11, 0, 4'd2, 0, 0);
    add_vec("hit_m1_c1",     0, 1, 3'd4, 3'd2, 3'd1, 2'b01, 1, 4'd3, 0, 0);

    bus.start = 1'b0; bus.move_valid = 1'b0; bus.player_x = 3'd0; bus.player_y = 3'd0;

    // Reset state.
    #3;
    check_all("reset", 3'd0, 2'b00, 1'b0, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Table-driven vectors: apply for one edge, then compare.
    foreach (vq[i]) begin
      bus.start      = vq[i].start;
      bus.move_valid = vq[i].mv;
      bus.player_x   = vq[i].x;
      bus.player_y   = vq[i].y;
      tick();
      bus.start      = 1'b0;
      bus.move_valid = 1'b0;
      check_all(vq[i].name, vq[i].e_map, vq[i].e_act, vq[i].e_pulse,
                vq[i].e_cnt, vq[i].e_ld, vq[i].e_gd);
    end

    // Asynchronous reset in PLAY with circle_active = 01: clears before the next edge.
    #2;
    rst = 1'b1;
    #1;
    check_all("async_rst", 3'd0, 2'b00, 1'b0, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("rst_release_idle.act", 32'(bus.circle_active), 32'd0);

    // Full five-map game.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("game_start.act_load", 32'(bus.circle_active), 32'd0);
    tick();
    check("game_start.act", 32'(bus.circle_active), 32'd3);
    for (int m = 0; m < 5; m++) play_level(m);

    // GAME_DONE holds and ignores moves.
    bus.move_valid = 1'b1; bus.player_x = 3'd1; bus.player_y = 3'd3;
    tick();
    bus.move_valid = 1'b0;
    check_all("gd_hold", 3'd4, 2'b00, 1'b0, 4'd10, 1'b0, 1'b1);

    // Restart from GAME_DONE.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check_all("restart", 3'd0, 2'b00, 1'b0, 4'd0, 1'b0, 1'b0);
    tick();
    check("restart.act", 32'(bus.circle_active), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/t07_circle_sequencer.md
# t07_circle_sequencer

Level controller for the circle overlay. It drives `map_select` into the circle pixel generator and tracks which of the map's two circles the player has collected. It also steps through the five maps and flags level and game completion to the top-level game FSM. The block sits between the player-movement logic (block coordinates) and the circle renderer.

## Interface
Parameters:
- `NUM_MAPS`, 5: number of maps sequenced; maps are 0 … NUM_MAPS-1; must be ≤ 5.
- `HOLD_CYCLES`, 16: cycles spent in LEVEL_DONE before advancing; must be ≥ 1.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse; begins the game from IDLE or GAME_DONE.
- `move_valid`  in  1  one-cycle pulse; player has entered the block at `player_x`/`player_y`.
- `player_x`  in  3  player block column, 0–5.
- `player_y`  in  3  player block row, 0–5.
- `map_select`  out  3  current map index to the circle generator.
- `circle_active`  out  2  bit i = 1 means circle i is still uncollected and rendered.
- `collect_pulse`  out  1  one-cycle pulse when a circle is collected.
- `collect_count`  out  4  total circles collected this game.
- `level_done`  out  1  one-cycle pulse when a map finishes.
- `game_done`  out  1  high while in GAME_DONE.

## Operation
- Circle table, as block (x,y), circle 0 then circle 1, combinational from `map_select`:
  - map 0: (0,3), (5,4)
  - map 1: (1,4), (4,2)
  - map 2: (0,2), (2,2)
  - map 3: (5,5), (5,2)
  - map 4: (1,3), (2,0)
  - other indices: (0,0), (0,0); these are unreachable.
- States: IDLE, LOAD, PLAY, LEVEL_DONE, GAME_DONE.
- IDLE: `circle_active`=00. On `start`: `map_select`←0, `collect_count`←0, go to LOAD.
- LOAD (one cycle): `circle_active`←11, hold counter←0, go to PLAY.
- PLAY, on `move_valid`:
  - For each i with `circle_active[i]`=1 and (`player_x`,`player_y`) equal to circle i: clear bit i.
  - In the same edge: `collect_pulse`←1 and `collect_count`+1.
  - Coordinates 6 or 7 never match.
  - If the clear leaves `circle_active`=00, go to LEVEL_DONE on the same edge.
- LEVEL_DONE:
  - Counter increments each cycle.
  - When counter = HOLD_CYCLES-1: `level_done`←1 for one cycle.
    - If `map_select` = NUM_MAPS-1: go to GAME_DONE.
    - Else: `map_select`+1, go to LOAD.
- GAME_DONE: `game_done`=1, `circle_active`=00. On `start`: same actions as `start` in IDLE.
- Ignored inputs:
  - `start` in LOAD, PLAY and LEVEL_DONE.
  - `move_valid` outside PLAY.
- `collect_count` saturates at 15; it cannot exceed 2·NUM_MAPS in normal play.
- Circle positions within one map are distinct, so a single move never clears both bits.

## Timing
- All outputs are registered.
- Reset values: state IDLE, `map_select`=0, `circle_active`=00, `collect_pulse`=0, `collect_count`=0, `level_done`=0, `game_done`=0, counter=0.
- `move_valid` sampled at edge N → `circle_active` and `collect_pulse` update at N (visible in cycle N+1); the pulse lasts exactly one cycle.
- Final collect at edge N → LEVEL_DONE from N. `level_done` is seen in cycle N+HOLD_CYCLES+1, together with the incremented `map_select`. `circle_active`=11 follows one cycle later (LOAD).
- `start` in IDLE at edge S → `circle_active`=11 visible from cycle S+2.
- `rst` asserted in any state clears everything immediately, independent of `clk`. Release takes effect on the next edge.
- A repeat `move_valid` onto an already-collected circle produces no pulse and no count change.

## Test plan
- Reset mid-PLAY with `circle_active`=01 → all outputs return to reset values before the next `clk` edge.
- `start`, then move to (0,3) → `circle_active`=10, `collect_pulse` for one cycle, `collect_count`=1. Move to (0,3) again → no change.
- Map 0: collect (0,3) then (5,4) → LEVEL_DONE. After HOLD_CYCLES: `level_done` pulse with `map_select`=1, then `circle_active`=11.
- Play all 5 maps in order using the table positions → `game_done`=1, `map_select`=4, `collect_count`=10. `start` → `map_select`=0, `collect_count`=0, `game_done`=0.
- `move_valid` with (6,3) and with (5,4) while on map 1 → no collect. `move_valid` in IDLE → ignored.
- `start` pulsed during PLAY and LEVEL_DONE → state, `map_select` and counter unaffected.
